ft232h_fifo_arbiter: RTL and testbench

Half-duplex bus scheduler for the FT232H asynchronous 245-FIFO interface. It shares the single bidirectional 8-bit data bus between the host-to-FPGA read path and the FPGA-to-host write path. It sequences RD#/WR# strobes, the FPGA pad output enable and the bus turnaround, and alternates priority when both directions are pending. It sits between the FT232H pads/tristate buffers and the internal RX byte sink and TX byte source.

---
 rtl/ft232h_fifo_arbiter_if.sv | 30 +++
 rtl/ft232h_fifo_arbiter.sv | 132 +++++++++++++
 tb/tb_ft232h_fifo_arbiter.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ft232h_fifo_arbiter_if.sv
// Signal bundle between the FT232H 245-FIFO arbiter and its environment
// (pads/tristate buffers on one side, RX sink and TX source on the other).
interface ft232h_fifo_arbiter_if;
  logic       i_rxf_n;
  logic       i_txe_n;
  logic [7:0] i_ft_data;
  logic [7:0] o_ft_data;
  logic       o_oe_drv;
  logic       o_rd_n;
  logic       o_wr_n;
  logic       i_rx_full;
  logic [7:0] o_rx_data;
  logic       o_rx_valid;
  logic [7:0] i_tx_data;
  logic       i_tx_valid;
  logic       o_tx_ready;
  logic       o_busy;

  modport master (
    input  i_rxf_n, i_txe_n, i_ft_data, i_rx_full, i_tx_data, i_tx_valid,
    output o_ft_data, o_oe_drv, o_rd_n, o_wr_n, o_rx_data, o_rx_valid,
           o_tx_ready, o_busy
  );

  modport slave (
    output i_rxf_n, i_txe_n, i_ft_data, i_rx_full, i_tx_data, i_tx_valid,
    input  o_ft_data, o_oe_drv, o_rd_n, o_wr_n, o_rx_data, o_rx_valid,
           o_tx_ready, o_busy
  );
endinterface

// File: rtl/ft232h_fifo_arbiter.sv
// Half-duplex scheduler for the FT232H 245-FIFO bus: sequences RD#/WR#, pad
// output enable and bus turnaround, alternating direction when both are pending.
module ft232h_fifo_arbiter #(
  parameter int RD_CYC    = 2,
  parameter int WR_CYC    = 2,
  parameter int SETUP_CYC = 1,
  parameter int PRE_CYC   = 1,
  parameter int TURN_CYC  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  ft232h_fifo_arbiter_if.master bus
);

  typedef enum logic [2:0] {
    IDLE, TURN, RD_STROBE, WR_SETUP, WR_STROBE, PRE
  } state_t;

  typedef enum logic {DIR_RD = 1'b0, DIR_WR = 1'b1} dir_t;

  localparam logic [3:0] RD_LD    = 4'(RD_CYC - 1);
  localparam logic [3:0] WR_LD    = 4'(WR_CYC - 1);
  localparam logic [3:0] SETUP_LD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] PRE_LD   = 4'(PRE_CYC - 1);
  localparam logic [3:0] TURN_LD  = 4'(TURN_CYC - 1);

  state_t     state;
  dir_t       last_dir;
  logic [3:0] cnt;

  logic rd_req;
  logic wr_req;
  logic grant_rd;
  logic grant_wr;

  assign rd_req = !bus.i_rxf_n && !bus.i_rx_full;
  assign wr_req = !bus.i_txe_n && bus.i_tx_valid;

  // On a tie the direction not served last wins; gated by reset so the TX
  // source never hands over a byte on an edge the FSM ignores.
  assign grant_rd = (state == IDLE) && !i_rst && rd_req && (!wr_req || last_dir == DIR_WR);
  assign grant_wr = (state == IDLE) && !i_rst && wr_req && (!rd_req || last_dir == DIR_RD);

  // NOTE: o_tx_ready is combinational so the byte is taken on the grant edge itself.
  assign bus.o_tx_ready = grant_wr;
  assign bus.o_busy     = (state != IDLE);

  // NOTE: all state and registered outputs use non-blocking assignments so every
  // branch sees the pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state          <= IDLE;
      last_dir       <= DIR_WR;
      cnt            <= '0;
      bus.o_rd_n     <= 1'b1;
      bus.o_wr_n     <= 1'b1;
      bus.o_oe_drv   <= 1'b0;
      bus.o_ft_data  <= '0;
      bus.o_rx_data  <= '0;
      bus.o_rx_valid <= 1'b0;
    end else begin
      bus.o_rx_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_rd) begin
            last_dir <= DIR_RD;
            if (bus.o_oe_drv) begin
              state        <= TURN;
              bus.o_oe_drv <= 1'b0;
              cnt          <= TURN_LD;
            end else begin
              state      <= RD_STROBE;
              bus.o_rd_n <= 1'b0;
              cnt        <= RD_LD;
            end
          end else if (grant_wr) begin
            last_dir      <= DIR_WR;
            bus.o_ft_data <= bus.i_tx_data;
            bus.o_oe_drv  <= 1'b1;
            state         <= WR_SETUP;
            cnt           <= SETUP_LD;
          end
        end
        TURN: begin
          if (cnt == 4'd0) begin
            state      <= RD_STROBE;
            bus.o_rd_n <= 1'b0;
            cnt        <= RD_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RD_STROBE: begin
          if (cnt == 4'd0) begin
            bus.o_rd_n     <= 1'b1;
            bus.o_rx_data  <= bus.i_ft_data;
            bus.o_rx_valid <= 1'b1;
            state          <= PRE;
            cnt            <= PRE_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_SETUP: begin
          if (cnt == 4'd0) begin
            bus.o_wr_n <= 1'b0;
            state      <= WR_STROBE;
            cnt        <= WR_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        WR_STROBE: begin
          if (cnt == 4'd0) begin
            bus.o_wr_n <= 1'b1;
            state      <= PRE;
            cnt        <= PRE_LD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        PRE: begin
          // Data and output enable stay put here to give the write its hold time.
          if (cnt == 4'd0) state <= IDLE;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ft232h_fifo_arbiter.sv
// Scoreboard bench for ft232h_fifo_arbiter: directed stimulus pushes expected
// grants/bytes into queues, a negedge monitor pops and compares on DUT events.
module tb_ft232h_fifo_arbiter;

  localparam int RD_CYC    = 2;
  localparam int WR_CYC    = 2;
  localparam int SETUP_CYC = 1;
  localparam int PRE_CYC   = 1;
  localparam int TURN_CYC  = 1;

  localparam logic [1:0] K_NONE = 2'd0;
  localparam logic [1:0] K_RD   = 2'd1;
  localparam logic [1:0] K_WR   = 2'd2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ft232h_fifo_arbiter_if bus ();

  ft232h_fifo_arbiter #(
    .RD_CYC(RD_CYC), .WR_CYC(WR_CYC), .SETUP_CYC(SETUP_CYC),
    .PRE_CYC(PRE_CYC), .TURN_CYC(TURN_CYC)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // FT232H receive FIFO and internal TX source models
  logic [7:0] rx_src[$];
  logic [7:0] tx_src[$];
  int         rx_n     = 0;
  int         tx_n     = 0;
  logic [7:0] rx_head  = 8'h00;
  logic [7:0] tx_head  = 8'h00;
  logic       rxf_kill = 1'b0;
  logic       rx_full  = 1'b0;

  function automatic void refresh();
    rx_n    = rx_src.size();
    tx_n    = tx_src.size();
    rx_head = (rx_n != 0) ? rx_src[0] : 8'h00;
    tx_head = (tx_n != 0) ? tx_src[0] : 8'h00;
  endfunction

  assign bus.i_rxf_n    = rxf_kill || (rx_n == 0);
  assign bus.i_txe_n    = 1'b0;
  assign bus.i_ft_data  = rx_head;
  assign bus.i_rx_full  = rx_full;
  assign bus.i_tx_valid = (tx_n != 0);
  assign bus.i_tx_data  = tx_head;

  initial begin : models
    logic take_tx;
    logic rd_q;
    rd_q = 1'b1;
    forever begin
      @(negedge clk);
      take_tx = !rst && bus.o_tx_ready && bus.i_tx_valid;
      if (rst) begin
        rd_q = 1'b1;
      end else begin
        if (bus.o_rd_n && !rd_q && rx_src.size() != 0) void'(rx_src.pop_front());
        rd_q = bus.o_rd_n;
      end
      refresh();
      @(posedge clk);
      #1;
      if (take_tx && tx_src.size() != 0) void'(tx_src.pop_front());
      refresh();
    end
  end

  // Scoreboard queues
  logic [1:0] exp_kind[$];
  logic [7:0] exp_rx[$];
  logic [7:0] exp_tx[$];
  int         test_id = 0;
  logic       gap_en  = 1'b0;

  initial begin : monitor
    int         cyc, seen_id, rd_len, wr_len, rd_start, acc_cyc, prev_start;
    logic       rd_prev, wr_prev;
    logic [1:0] prev_kind;
    cyc = 0; seen_id = 0; rd_len = 0; wr_len = 0; rd_start = 0; acc_cyc = 0;
    prev_start = 0; rd_prev = 1'b1; wr_prev = 1'b1; prev_kind = K_NONE;
    forever begin
      @(negedge clk);
      cyc++;
      if (test_id != seen_id) begin
        seen_id   = test_id;
        prev_kind = K_NONE;
      end
      if (rst) begin
        rd_prev = 1'b1; wr_prev = 1'b1; rd_len = 0; wr_len = 0; prev_kind = K_NONE;
      end else begin
        if (!bus.o_rd_n) begin
          check("rd_wr_overlap", bus.o_wr_n, 1);
          check("rd_while_oe", bus.o_oe_drv, 0);
          rd_len++;
          if (rd_prev) begin
            if (exp_kind.size() == 0) check("rd_grant_expected", exp_kind.size(), 1);
            else check("grant_order_rd", exp_kind.pop_front(), K_RD);
            if (gap_en && prev_kind == K_RD) check("rd_rd_gap", cyc - prev_start, RD_CYC + PRE_CYC + 1);
            if (gap_en && prev_kind == K_WR) check("wr_rd_gap", cyc - prev_start, WR_CYC + PRE_CYC + 1 + TURN_CYC);
            prev_kind = K_RD; prev_start = cyc; rd_start = cyc;
          end
        end else if (!rd_prev) begin
          check("rd_len", rd_len, RD_CYC);
          rd_len = 0;
        end

        if (!bus.o_wr_n) begin
          wr_len++;
          if (wr_prev) begin
            if (exp_kind.size() == 0) check("wr_grant_expected", exp_kind.size(), 1);
            else check("grant_order_wr", exp_kind.pop_front(), K_WR);
            if (exp_tx.size() == 0) check("wr_data_expected", exp_tx.size(), 1);
            else check("wr_data", bus.o_ft_data, exp_tx.pop_front());
            check("wr_oe", bus.o_oe_drv, 1);
            check("wr_setup_lat", cyc - acc_cyc, SETUP_CYC + 1);
            if (gap_en && prev_kind == K_RD) check("rd_wr_gap", cyc - prev_start, RD_CYC + PRE_CYC + 1 + SETUP_CYC);
            if (gap_en && prev_kind == K_WR) check("wr_wr_gap", cyc - prev_start, WR_CYC + PRE_CYC + 1 + SETUP_CYC);
            prev_kind = K_WR; prev_start = cyc;
          end
        end else if (!wr_prev) begin
          check("wr_len", wr_len, WR_CYC);
          wr_len = 0;
        end

        if (bus.o_rx_valid) begin
          if (exp_rx.size() == 0) check("rx_expected", exp_rx.size(), 1);
          else check("rx_data", bus.o_rx_data, exp_rx.pop_front());
          check("rx_latency", cyc - rd_start, RD_CYC);
        end

        if (bus.o_tx_ready && bus.i_tx_valid) begin
          acc_cyc = cyc;
          check("tx_ready_idle", bus.o_busy, 0);
          if (prev_kind == K_WR) check("wr_wr_oe_held", bus.o_oe_drv, 1);
        end

        rd_prev = bus.o_rd_n;
        wr_prev = bus.o_wr_n;
      end
    end
  end

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_kind.size() != 0 || exp_rx.size() != 0 || bus.o_busy) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (3) begin
      @(posedge clk); #1;
    end
    check({name, "_drained"}, exp_kind.size() + exp_rx.size() + exp_tx.size(), 0);
    check({name, "_idle"}, bus.o_busy, 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    test_id++;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : stimulus
    refresh();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rd_n", bus.o_rd_n, 1);
    check("rst_wr_n", bus.o_wr_n, 1);
    check("rst_oe", bus.o_oe_drv, 0);
    check("rst_ft_data", bus.o_ft_data, 0);
    check("rst_rx_data", bus.o_rx_data, 0);
    check("rst_rx_valid", bus.o_rx_valid, 0);
    check("rst_busy", bus.o_busy, 0);
    check("rst_tx_ready", bus.o_tx_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Read only: two back-to-back reads, bus never driven
    test_id = 1; gap_en = 1'b1;
    exp_kind = '{K_RD, K_RD}; exp_rx = '{8'h11, 8'h22};
    rx_src = '{8'h11, 8'h22}; refresh();
    drain("rd_only");
    check("rd_only_oe", bus.o_oe_drv, 0);

    // Write only: 0xA5 then 0x5A, 5 cycles apart
    test_id = 2;
    exp_kind = '{K_WR, K_WR}; exp_tx = '{8'hA5, 8'h5A};
    tx_src = '{8'hA5, 8'h5A}; refresh();
    drain("wr_only");
    check("wr_only_oe_held", bus.o_oe_drv, 1);
    check("wr_only_data_held", bus.o_ft_data, 8'h5A);

    // Both pending from reset: R W R W with turnaround before each later read
    do_reset();
    test_id = 3;
    exp_kind = '{K_RD, K_WR, K_RD, K_WR};
    exp_rx = '{8'hA1, 8'hA2}; exp_tx = '{8'hB1, 8'hB2};
    rx_src = '{8'hA1, 8'hA2}; tx_src = '{8'hB1, 8'hB2}; refresh();
    drain("alternate");

    // RX sink full: reads suppressed, writes proceed, then the read follows
    test_id = 4; gap_en = 1'b0; rx_full = 1'b1;
    exp_kind = '{K_WR, K_WR}; exp_tx = '{8'hC3, 8'h81};
    rx_src = '{8'h44}; tx_src = '{8'hC3, 8'h81}; refresh();
    drain("rx_full_wr");
    check("rx_full_byte_pending", rx_n, 1);
    exp_kind = '{K_RD}; exp_rx = '{8'h44};
    rx_full = 1'b0;
    drain("rx_full_release");

    // RXF# rises during the second RD# cycle: strobe still completes
    test_id = 5;
    exp_kind = '{K_RD}; exp_rx = '{8'h5E};
    rx_src = '{8'h5E, 8'h6F}; refresh();
    for (int n = 0; n < 50 && bus.o_rd_n; n++) begin
      @(posedge clk); #1;
    end
    check("rxf_drop_rd_seen", bus.o_rd_n, 0);
    @(posedge clk); #1;
    rxf_kill = 1'b1;
    drain("rxf_drop");
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("rxf_drop_stays_idle", bus.o_busy, 0);
    check("rxf_drop_second_unread", rx_n, 2 - 1);
    rx_src.delete(); rxf_kill = 1'b0; refresh();

    // Reset during WR# strobe of 0x3C, then first tie goes to read
    test_id = 6;
    exp_kind = '{K_WR}; exp_tx = '{8'h3C};
    tx_src = '{8'h3C}; refresh();
    for (int n = 0; n < 50 && bus.o_wr_n; n++) @(negedge clk);
    check("rst_mid_wr_seen", bus.o_wr_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_wr_n", bus.o_wr_n, 1);
    check("rst_mid_oe", bus.o_oe_drv, 0);
    check("rst_mid_busy", bus.o_busy, 0);
    check("rst_mid_tx_lost", tx_n, 0);
    exp_kind = '{K_RD, K_WR}; exp_rx = '{8'h66}; exp_tx = '{8'h77};
    rx_src = '{8'h66}; tx_src = '{8'h77}; refresh();
    @(negedge clk);
    rst = 1'b0;
    test_id = 7;
    drain("post_rst_tie");

    check("end_rx_queue", exp_rx.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
